// File: rtl/arp_pkg.sv
// rtl/arp_pkg.sv - ARP body constants, error codes and parser state encoding.
package arp_pkg;
  localparam int ARP_BODY_BYTES = 28;
  localparam int ARP_BODY_W     = ARP_BODY_BYTES * 8;

  localparam logic [15:0] HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  HLEN_ETH   = 8'd6;
  localparam logic [7:0]  PLEN_IPV4  = 8'd4;
  localparam logic [15:0] OPER_REQ   = 16'd1;
  localparam logic [15:0] OPER_REP   = 16'd2;

  localparam logic [1:0] ERR_RUNT = 2'd0;
  localparam logic [1:0] ERR_HDR  = 2'd1;
  localparam logic [1:0] ERR_OPER = 2'd2;
  localparam logic [1:0] ERR_IP   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_CHECK   = 3'd3,
    ST_HOLD    = 3'd4
  } arp_state_t;
endpackage

// File: rtl/arp_hdr_check.sv
// rtl/arp_hdr_check.sv - combinational ARP body validation and error classification.
// Optional target-IP filter enabled by ARP_IP_FILTER_EN.
module arp_hdr_check
  import arp_pkg::*;
(
  input  logic [ARP_BODY_W-1:0] body,
  input  logic [31:0]           local_ip,
  output logic                  ok,
  output logic [1:0]            err_code
);
  logic [15:0] htype;
  logic [15:0] ptype;
  logic [7:0]  hlen;
  logic [7:0]  plen;
  logic [15:0] oper;
  logic [31:0] tpa;
  logic        hdr_bad;
  logic        oper_bad;
  logic        unused_bits;

  assign htype = body[223:208];
  assign ptype = body[207:192];
  assign hlen  = body[191:184];
  assign plen  = body[183:176];
  assign oper  = body[175:160];
  assign tpa   = body[31:0];

  assign hdr_bad  = (htype != HTYPE_ETH) || (ptype != PTYPE_IPV4) ||
                    (hlen != HLEN_ETH) || (plen != PLEN_IPV4);
  assign oper_bad = !((oper == OPER_REQ) || (oper == OPER_REP));

`ifdef ARP_IP_FILTER_EN
  assign unused_bits = ^body[159:32];

  always_comb begin
    ok       = 1'b1;
    err_code = ERR_RUNT;
    if (hdr_bad) begin
      ok       = 1'b0;
      err_code = ERR_HDR;
    end else if (oper_bad) begin
      ok       = 1'b0;
      err_code = ERR_OPER;
    end else if (tpa != local_ip) begin
      ok       = 1'b0;
      err_code = ERR_IP;
    end
  end
`else
  assign unused_bits = ^{body[159:32], tpa, local_ip};

  always_comb begin
    ok       = 1'b1;
    err_code = ERR_RUNT;
    if (hdr_bad) begin
      ok       = 1'b0;
      err_code = ERR_HDR;
    end else if (oper_bad) begin
      ok       = 1'b0;
      err_code = ERR_OPER;
    end
  end
`endif
endmodule

// File: rtl/arp_rx_parser.sv
// rtl/arp_rx_parser.sv - streaming ARP body parser with held output record.
// ARP_IP_FILTER_EN drops frames whose target IP differs from local_ip.
module arp_rx_parser
  import arp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [31:0]       local_ip,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       hdr_type,
  output logic [15:0]       proto_type,
  output logic [7:0]        hdr_addr_length,
  output logic [7:0]        pro_addr_length,
  output logic [15:0]       operation,
  output logic [47:0]       send_hdr_addr,
  output logic [47:0]       target_hdr_addr,
  output logic [31:0]       send_ip_addr,
  output logic [31:0]       target_ip_addr,
  output logic              err,
  output logic [1:0]        err_code
);
  localparam int NBEATS = ARP_BODY_W / DATA_W;
  localparam int CNT_W  = $clog2(NBEATS + 1);

  arp_state_t             state;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_nxt;
  logic [ARP_BODY_W-1:0]  shift_reg;
  logic                   accept;
  logic                   chk_ok;
  logic [1:0]             chk_code;

  assign accept    = in_valid && in_ready;
  assign count_nxt = count + CNT_W'(1);

  arp_hdr_check u_hdr_check (
    .body     (shift_reg),
    .local_ip (local_ip),
    .ok       (chk_ok),
    .err_code (chk_code)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      count           <= '0;
      shift_reg       <= '0;
      in_ready        <= 1'b0;
      out_valid       <= 1'b0;
      err             <= 1'b0;
      err_code        <= ERR_RUNT;
      hdr_type        <= '0;
      proto_type      <= '0;
      hdr_addr_length <= '0;
      pro_addr_length <= '0;
      operation       <= '0;
      send_hdr_addr   <= '0;
      target_hdr_addr <= '0;
      send_ip_addr    <= '0;
      target_ip_addr  <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            shift_reg <= {shift_reg[ARP_BODY_W-DATA_W-1:0], in_data};
            if (in_last) begin
              err      <= 1'b1;
              err_code <= ERR_RUNT;
              count    <= '0;
            end else begin
              count <= CNT_W'(1);
              state <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            shift_reg <= {shift_reg[ARP_BODY_W-DATA_W-1:0], in_data};
            count     <= count_nxt;
            if (count_nxt == CNT_W'(NBEATS)) begin
              if (in_last) begin
                state    <= ST_CHECK;
                in_ready <= 1'b0;
              end else begin
                state <= ST_DRAIN;
              end
            end else if (in_last) begin
              err      <= 1'b1;
              err_code <= ERR_RUNT;
              count    <= '0;
              state    <= ST_IDLE;
            end
          end
        end
        // Padding after a full body is swallowed until the frame ends.
        ST_DRAIN: begin
          if (accept && in_last) begin
            state    <= ST_CHECK;
            in_ready <= 1'b0;
          end
        end
        ST_CHECK: begin
          count <= '0;
          if (chk_ok) begin
            hdr_type        <= shift_reg[223:208];
            proto_type      <= shift_reg[207:192];
            hdr_addr_length <= shift_reg[191:184];
            pro_addr_length <= shift_reg[183:176];
            operation       <= shift_reg[175:160];
            send_hdr_addr   <= shift_reg[159:112];
            send_ip_addr    <= shift_reg[111:80];
            target_hdr_addr <= shift_reg[79:32];
            target_ip_addr  <= shift_reg[31:0];
            out_valid       <= 1'b1;
            state           <= ST_HOLD;
          end else begin
            err      <= 1'b1;
            err_code <= chk_code;
            in_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_arp_rx_parser.sv
// tb/tb_arp_rx_parser.sv - directed self-checking bench for arp_rx_parser (DATA_W 32 and 8).
module tb_arp_rx_parser;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] local_ip = 32'h0A000009;

  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, err;
  logic [1:0]  err_code;
  logic [15:0] hdr_type, proto_type, operation;
  logic [7:0]  hdr_addr_length, pro_addr_length;
  logic [47:0] send_hdr_addr, target_hdr_addr;
  logic [31:0] send_ip_addr, target_ip_addr;

  logic [7:0]  in_data8 = '0;
  logic        in_valid8 = 1'b0, in_last8 = 1'b0, out_ready8 = 1'b0;
  logic        in_ready8, out_valid8, err8;
  logic [1:0]  err_code8;
  logic [15:0] hdr_type8, proto_type8, operation8;
  logic [7:0]  hdr_addr_length8, pro_addr_length8;
  logic [47:0] send_hdr_addr8, target_hdr_addr8;
  logic [31:0] send_ip_addr8, target_ip_addr8;

  logic [223:0] rec, rec8;
  int tests_run = 0;
  int tests_failed = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  arp_rx_parser #(.DATA_W(32)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .local_ip(local_ip), .out_valid(out_valid), .out_ready(out_ready),
    .hdr_type(hdr_type), .proto_type(proto_type), .hdr_addr_length(hdr_addr_length),
    .pro_addr_length(pro_addr_length), .operation(operation), .send_hdr_addr(send_hdr_addr),
    .target_hdr_addr(target_hdr_addr), .send_ip_addr(send_ip_addr),
    .target_ip_addr(target_ip_addr), .err(err), .err_code(err_code)
  );

  arp_rx_parser #(.DATA_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_last(in_last8), .local_ip(local_ip), .out_valid(out_valid8), .out_ready(out_ready8),
    .hdr_type(hdr_type8), .proto_type(proto_type8), .hdr_addr_length(hdr_addr_length8),
    .pro_addr_length(pro_addr_length8), .operation(operation8), .send_hdr_addr(send_hdr_addr8),
    .target_hdr_addr(target_hdr_addr8), .send_ip_addr(send_ip_addr8),
    .target_ip_addr(target_ip_addr8), .err(err8), .err_code(err_code8)
  );

  assign rec  = {hdr_type, proto_type, hdr_addr_length, pro_addr_length, operation,
                 send_hdr_addr, send_ip_addr, target_hdr_addr, target_ip_addr};
  assign rec8 = {hdr_type8, proto_type8, hdr_addr_length8, pro_addr_length8, operation8,
                 send_hdr_addr8, send_ip_addr8, target_hdr_addr8, target_ip_addr8};

  always @(posedge clk) if (rst && err) err_cnt++;

  function automatic logic [223:0] mk_body(input logic [15:0] htype, input logic [15:0] oper,
                                           input logic [31:0] tpa);
    return {htype, 16'h0800, 8'd6, 8'd4, oper, 48'h001122334455, 32'h0A000001, 48'h0, tpa};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put_beat(input logic [31:0] d, input logic last);
    int n = 0;
    in_data = d; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 50) begin tick(); n++; end
    tests_run++;
    if (n >= 50) begin tests_failed++; $display("FAIL beat_accept_timeout: in_ready=%b required 1", in_ready); end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input logic [223:0] body, input int nb);
    for (int i = 0; i < nb; i++)
      put_beat((i < 7) ? body[223-32*i -: 32] : (32'hDEAD0000 | i), i == nb - 1);
  endtask

  task automatic release_record();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    tests_run++;
    if ({in_ready, out_valid, err, err_code} !== 5'b0) begin tests_failed++;
      $display("FAIL reset_ctrl: got %b required 00000", {in_ready, out_valid, err, err_code}); end
    tests_run++;
    if (rec !== 224'h0) begin tests_failed++; $display("FAIL reset_fields: got %h required 0", rec); end
    rst = 1'b1; tick();
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_idle_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [223:0] b = mk_body(16'h0001, 16'h0001, 32'h0A000002);
    send_frame(b, 7);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin tests_failed++;
      $display("FAIL basic_check_cycle: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready); end
    tick();
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_latency: got %b required 1", out_valid); end
    tests_run++;
    if (operation !== 16'h0001 || target_ip_addr !== 32'h0A000002) begin tests_failed++;
      $display("FAIL basic_oper_tpa: got %h %h required 0001 0a000002", operation, target_ip_addr); end
    tests_run++;
    if (rec !== b) begin tests_failed++; $display("FAIL basic_record: got %h required %h", rec, b); end
    release_record();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready); end
  endtask

  task automatic test_padding();
    logic [223:0] b = mk_body(16'h0001, 16'h0001, 32'h0A000002);
    int e0 = err_cnt;
    send_frame(b, 11);
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || rec !== b) begin tests_failed++;
      $display("FAIL padding_record: valid=%b got %h required %h", out_valid, rec, b); end
    tests_run++;
    if (err_cnt !== e0) begin tests_failed++; $display("FAIL padding_no_err: got %0d required %0d", err_cnt, e0); end
    release_record();
  endtask

  task automatic test_runt();
    logic [223:0] prev = rec;
    send_frame(mk_body(16'h0001, 16'h0002, 32'h0A000003), 5);
    tests_run++;
    if (err !== 1'b1 || err_code !== 2'd0) begin tests_failed++;
      $display("FAIL runt_err: err=%b code=%0d required 1 0", err, err_code); end
    tick(); tick();
    tests_run++;
    if (err !== 1'b0 || out_valid !== 1'b0 || rec !== prev) begin tests_failed++;
      $display("FAIL runt_after: err=%b valid=%b rec=%h required 0 0 %h", err, out_valid, rec, prev); end
    put_beat(32'h00010800, 1'b1);
    tests_run++;
    if (err !== 1'b1 || err_code !== 2'd0) begin tests_failed++;
      $display("FAIL single_beat_runt: err=%b code=%0d required 1 0", err, err_code); end
  endtask

  task automatic test_bad_frame(input string name, input logic [15:0] htype, input logic [15:0] oper,
                                input logic [1:0] code);
    logic [223:0] prev = rec;
    send_frame(mk_body(htype, oper, 32'h0A000002), 7);
    tick();
    tests_run++;
    if (err !== 1'b1 || err_code !== code) begin tests_failed++;
      $display("FAIL %s: err=%b code=%0d required 1 %0d", name, err, err_code, code); end
    tick();
    tests_run++;
    if (err !== 1'b0 || out_valid !== 1'b0 || rec !== prev) begin tests_failed++;
      $display("FAIL %s_after: err=%b valid=%b rec=%h required 0 0 %h", name, err, out_valid, rec, prev); end
  endtask

  task automatic test_hold_stall();
    logic [223:0] b1 = mk_body(16'h0001, 16'h0002, 32'h0A0000FE);
    logic [223:0] b2 = mk_body(16'h0001, 16'h0001, 32'h0A000002);
    int bad = 0;
    send_frame(b1, 7);
    tick();
    in_data = b2[223:192]; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || rec !== b1) bad++;
      tick();
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL hold_stall: %0d bad cycles required 0", bad); end
    in_valid = 1'b0;
    release_record();
    send_frame(b2, 7);
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || rec !== b2) begin tests_failed++;
      $display("FAIL after_stall: valid=%b got %h required %h", out_valid, rec, b2); end
    release_record();
  endtask

  task automatic test_ip_filter();
    logic [223:0] b = mk_body(16'h0001, 16'h0001, 32'h0A000002);
    send_frame(b, 7);
    tick();
`ifdef ARP_IP_FILTER_EN
    tests_run++;
    if (err !== 1'b1 || err_code !== 2'd3 || out_valid !== 1'b0) begin tests_failed++;
      $display("FAIL ip_filter: err=%b code=%0d valid=%b required 1 3 0", err, err_code, out_valid); end
`else
    tests_run++;
    if (out_valid !== 1'b1 || err !== 1'b0 || rec !== b) begin tests_failed++;
      $display("FAIL ip_nofilter: valid=%b err=%b rec=%h required 1 0 %h", out_valid, err, rec, b); end
    release_record();
`endif
  endtask

  task automatic test_mid_reset();
    logic [223:0] b = mk_body(16'h0001, 16'h0001, 32'h0A000002);
    int e0 = err_cnt;
    for (int i = 0; i < 3; i++) put_beat(b[223-32*i -: 32], 1'b0);
    rst = 1'b0; tick(); rst = 1'b1; tick();
    tests_run++;
    if (err_cnt !== e0 || out_valid !== 1'b0 || rec !== 224'h0) begin tests_failed++;
      $display("FAIL mid_reset: errs=%0d valid=%b rec=%h required %0d 0 0", err_cnt, out_valid, rec, e0); end
    send_frame(b, 7);
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || rec !== b) begin tests_failed++;
      $display("FAIL post_reset_frame: valid=%b got %h required %h", out_valid, rec, b); end
    release_record();
  endtask

  task automatic test_width8();
    logic [223:0] b = mk_body(16'h0001, 16'h0001, 32'h0A000002);
    int n;
    for (int i = 0; i < 28; i++) begin
      n = 0;
      in_data8 = b[223-8*i -: 8]; in_last8 = (i == 27); in_valid8 = 1'b1;
      while (!in_ready8 && n < 50) begin tick(); n++; end
      tick();
    end
    in_valid8 = 1'b0; in_last8 = 1'b0;
    tests_run++;
    if (out_valid8 !== 1'b0) begin tests_failed++; $display("FAIL w8_check_cycle: got %b required 0", out_valid8); end
    tick();
    tests_run++;
    if (out_valid8 !== 1'b1 || rec8 !== b) begin tests_failed++;
      $display("FAIL w8_record: valid=%b got %h required %h", out_valid8, rec8, b); end
    out_ready8 = 1'b1; tick(); out_ready8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_padding();
    test_runt();
    test_bad_frame("htype_err", 16'h0006, 16'h0001, 2'd1);
    test_bad_frame("oper_err", 16'h0001, 16'h0003, 2'd2);
    test_bad_frame("priority_err", 16'h0006, 16'h0003, 2'd1);
    test_hold_stall();
    test_ip_filter();
    test_mid_reset();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
